// File: rtl/tt_um_symmetry_detector.sv
// Bit-palindrome detector: combinational mirror-pair check of ui_in, plus a
// registered copy of the symmetric flag and a saturating symmetric-sample count.
module tt_um_symmetry_detector (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] pair_mismatch;
  logic [2:0] mismatch_count;
  logic       symmetric;
  logic       sym_q;
  logic [2:0] cnt;
  logic       unused_ok;

  // Pair i compares bit i with its mirror bit 7-i.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pair_mismatch[i] = ui_in[i] ^ ui_in[7-i];
    end
  end

  assign mismatch_count = {2'b00, pair_mismatch[0]} + {2'b00, pair_mismatch[1]}
                        + {2'b00, pair_mismatch[2]} + {2'b00, pair_mismatch[3]};
  assign symmetric = (pair_mismatch == 4'b0000);

  // Reset wins over ena; the count saturates at 7 instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_q <= 1'b0;
      cnt   <= 3'd0;
    end else if (ena) begin
      sym_q <= symmetric;
      if (symmetric && (cnt != 3'd7)) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign uo_out    = {cnt, sym_q, mismatch_count, symmetric};
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{1'b0, uio_in};

endmodule

// File: tb/tb_tt_um_symmetry_detector.sv
// Self-checking bench for tt_um_symmetry_detector: direct combinational checks
// with the clock idle, then a queue-based scoreboard for the registered path.
module tb_tt_um_symmetry_detector;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    string      tag;
    logic [7:0] value;
  } exp_t;

  exp_t       scoreboard[$];
  exp_t       item;
  int         testsRun;
  int         testsFailed;
  logic       modelSym;
  logic [2:0] modelCnt;

  tt_um_symmetry_detector dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = clk_run ? ~clk : clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Expected uo_out[3:0] straight from the mirrored-pair definition.
  function automatic logic [3:0] expectedComb(input logic [7:0] d);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (d[i] != d[7-i]) c++;
    end
    return {c[2:0], (c == 0)};
  endfunction

  // Drive one clock's worth of inputs at the falling edge and queue the
  // uo_out value expected after the following rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic rst_val, input logic en_val, input string tag);
    logic [3:0] comb;
    exp_t       e;
    @(negedge clk);
    ui_in = data;
    rst_n = rst_val;
    ena   = en_val;
    #1;
    comb = expectedComb(data);
    checkOutput({tag, "_comb"}, {28'd0, uo_out[3:0]}, {28'd0, comb});
    if (!rst_val) begin
      modelSym = 1'b0;
      modelCnt = 3'd0;
    end else if (en_val) begin
      if (comb[0] && modelCnt != 3'd7) modelCnt = modelCnt + 3'd1;
      modelSym = comb[0];
    end
    e.tag   = tag;
    e.value = {modelCnt, modelSym, comb};
    scoreboard.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (scoreboard.size() > 0) begin
      item = scoreboard.pop_front();
      checkOutput(item.tag, {24'd0, uo_out}, {24'd0, item.value});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] combVectors[6];
    logic [7:0] r;
    testsRun    = 0;
    testsFailed = 0;
    clk_run     = 1'b0;
    rst_n       = 1'b0;
    ena         = 1'b0;
    uio_in      = 8'hA5;
    ui_in       = 8'h00;
    modelSym    = 1'b0;
    modelCnt    = 3'd0;

    // Clock stopped, reset asserted: low nibble must still track ui_in.
    combVectors = '{8'b00000000, 8'b11010011, 8'b11000011, 8'b11111111, 8'b10010110, 8'b00000001};
    #2;
    checkOutput("idle_zero", {28'd0, uo_out[3:0]}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      ui_in = combVectors[i];
      #1;
      checkOutput($sformatf("idle_vec%0d", i), {28'd0, uo_out[3:0]}, {28'd0, expectedComb(combVectors[i])});
    end
    ui_in = 8'b11010011;
    #1;
    checkOutput("idle_one_pair", {28'd0, uo_out[3:0]}, 32'h2);
    ui_in = 8'b10010110;
    #1;
    checkOutput("idle_all_pairs", {28'd0, uo_out[3:0]}, 32'h8);
    checkOutput("uio_out_zero", {24'd0, uio_out}, 32'h0);
    checkOutput("uio_oe_zero", {24'd0, uio_oe}, 32'h0);

    clk_run = 1'b1;
    applyStimulus(8'h81, 1'b0, 1'b1, "reset0");
    applyStimulus(8'h81, 1'b0, 1'b1, "reset1");
    for (int i = 0; i < 9; i++) applyStimulus(8'h81, 1'b1, 1'b1, $sformatf("sat%0d", i));
    applyStimulus(8'h80, 1'b1, 1'b1, "asym_after_sat");
    applyStimulus(8'h80, 1'b0, 1'b1, "reset2");
    for (int i = 0; i < 3; i++) applyStimulus(8'h81, 1'b1, 1'b1, $sformatf("cnt3_%0d", i));
    for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 8'h3C : 8'h01, 1'b1, 1'b0, $sformatf("hold%0d", i));
    applyStimulus(8'h81, 1'b0, 1'b1, "reset_priority");
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 255);
      if (i % 3 == 0) r = {r[0], r[1], r[2], r[3], r[3], r[2], r[1], r[0]};
      applyStimulus(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", scoreboard.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
